// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream arbiter.
package stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_FLUSH
    } stream_arb_st_t;

    // Narrowest counter we ever build, even when only one value is needed.
    localparam int MIN_IDX_W = 1;

    // Width of an index that counts 0..n-1.
    function automatic int idx_w(input int n);
        return (n <= 2) ? MIN_IDX_W : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first active request at or after the pointer, wrapping.
module rr_pick
    import stream_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [PW-1:0] idx,
    output logic          any
);

    int            pos;
    logic [PW-1:0] pos_w;

    // Scan every position once starting at ptr; the first hit wins.
    always_comb begin
        pick  = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        pos_w = '0;
        for (int k = 0; k < N; k++) begin
            pos   = (int'(ptr) + k) % N;
            pos_w = PW'(pos);
            if (!any && req[pos_w]) begin
                pick[pos_w] = 1'b1;
                idx         = pos_w;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_arb.sv
// Round-robin arbiter pulling fixed-length bursts from several sources onto one AXI-Stream master.
module stream_arb
    import stream_pkg::*;
#(
    parameter  int REQNUM = 4,
    parameter  int DW     = 32,
    parameter  int BEATS  = 4,
    localparam int BW     = idx_w(BEATS),
    localparam int PW     = idx_w(REQNUM)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REQNUM-1:0]    req,
    input  logic [REQNUM*DW-1:0] src_d,
    output logic [REQNUM-1:0]    gnt,
    output logic                 rd_v,
    output logic [BW-1:0]        rd_i,
    output logic [REQNUM-1:0]    done,
    input  logic                 dst_ready,
    output logic                 dst_valid,
    output logic [DW-1:0]        dst_data,
    output logic                 dst_last
);

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [PW-1:0] LAST_SRC  = PW'(REQNUM - 1);

    stream_arb_st_t    state, state_n;
    logic [PW-1:0]     ptr, gidx, pick_idx;
    logic [REQNUM-1:0] pick;
    logic              pick_any;
    logic [BW-1:0]     beat;
    logic              adv, last_beat;
    logic              take, issue, finish;

    rr_pick #(
        .N  (REQNUM),
        .PW (PW)
    ) u_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // The output slot can accept a new word when it is empty or being drained this cycle.
    assign adv       = !dst_valid || dst_ready;
    assign last_beat = (beat == LAST_BEAT);
    assign rd_i      = beat;
    assign rd_v      = issue;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    // Next state plus the one-cycle control strobes that drive the datapath.
    always_comb begin
        state_n = state;
        take    = 1'b0;
        issue   = 1'b0;
        finish  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    take    = 1'b1;
                    state_n = ST_SEND;
                end
            end
            ST_SEND: begin
                if (adv) begin
                    issue = 1'b1;
                    if (last_beat) state_n = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (dst_valid && dst_ready && dst_last) begin
                    finish  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Grant, beat counter, done pulse and rotation pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt  <= '0;
            gidx <= '0;
            ptr  <= '0;
            beat <= '0;
            done <= '0;
        end else begin
            done <= '0;
            if (take) begin
                gnt  <= pick;
                gidx <= pick_idx;
                beat <= '0;
            end
            if (issue) beat <= last_beat ? '0 : beat + 1'b1;
            if (finish) begin
                gnt  <= '0;
                done <= gnt;
                ptr  <= (gidx == LAST_SRC) ? '0 : gidx + 1'b1;
            end
        end
    end

    // Output register: loads only when the slot can advance, so it holds steady under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_valid <= 1'b0;
            dst_data  <= '0;
            dst_last  <= 1'b0;
        end else if (issue) begin
            dst_valid <= 1'b1;
            dst_data  <= src_d[gidx*DW +: DW];
            dst_last  <= last_beat;
        end else if (finish) begin
            dst_valid <= 1'b0;
            dst_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_arb.sv
// Directed bench for stream_arb: 4-beat instance plus a 1-beat instance.
module tb_stream_arb;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   pend;
    logic [3:0]   req;
    logic [127:0] src_d;
    logic [3:0]   gnt, done;
    logic         rd_v;
    logic [1:0]   rd_i;
    logic         dst_ready, dst_valid, dst_last;
    logic [31:0]  dst_data;

    logic [3:0]   b1_req;
    logic [127:0] b1_src_d;
    logic [3:0]   b1_gnt, b1_done;
    logic         b1_rd_v;
    logic [0:0]   b1_rd_i;
    logic         b1_ready, b1_valid, b1_last;
    logic [31:0]  b1_data;

    int n_chk  = 0;
    int n_fail = 0;
    int n_gnt  = 0;
    int n_done = 0;
    int n_beat = 0;
    int n_last = 0;
    bit mon_en = 1'b0;
    int exp_q[$];

    always #5 clk = ~clk;

    stream_arb #(.REQNUM(4), .DW(32), .BEATS(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .src_d(src_d), .gnt(gnt),
        .rd_v(rd_v), .rd_i(rd_i), .done(done), .dst_ready(dst_ready),
        .dst_valid(dst_valid), .dst_data(dst_data), .dst_last(dst_last)
    );

    stream_arb #(.REQNUM(4), .DW(32), .BEATS(1)) u_b1 (
        .clk(clk), .rst_n(rst_n), .req(b1_req), .src_d(b1_src_d), .gnt(b1_gnt),
        .rd_v(b1_rd_v), .rd_i(b1_rd_i), .done(b1_done), .dst_ready(b1_ready),
        .dst_valid(b1_valid), .dst_data(b1_data), .dst_last(b1_last)
    );

    // Source word for source s, beat b; source 2 gives 0xA0+b.
    function automatic logic [31:0] word(input int s, input int b);
        return 32'((s ^ 2) << 8) + 32'hA0 + 32'(b);
    endfunction

    // A source withdraws its request in the cycle its done pulse arrives.
    assign req = pend & ~done;

    // Sources answer the pull index combinationally.
    always_comb begin
        src_d    = '0;
        b1_src_d = '0;
        for (int i = 0; i < 4; i++) begin
            src_d[i*32 +: 32]    = word(i, int'(rd_i));
            b1_src_d[i*32 +: 32] = word(i, int'(b1_rd_i));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int k = 0; k < budget && n_done < target; k++) begin
            @(negedge clk);
            #1;
        end
        chk("wait_done", 32'(n_done), 32'(target));
    endtask

    task automatic wait_gnt(input int target, input int budget);
        for (int k = 0; k < budget && n_gnt < target; k++) begin
            @(negedge clk);
            #1;
        end
        chk("wait_gnt", 32'(n_gnt), 32'(target));
    endtask

    // Scoreboard: grant order, beat data/last, stability under stall, done pulses.
    initial begin
        int          cur = 0;
        int          bcnt = 0;
        logic [3:0]  prev_gnt = '0;
        bit          prev_stall = 1'b0;
        logic [31:0] prev_data = '0;
        logic        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_gnt   = '0;
                prev_stall = 1'b0;
            end else begin
                if (gnt != 4'd0 && prev_gnt == 4'd0) begin
                    n_gnt++;
                    bcnt = 0;
                    if (exp_q.size() == 0) chk("gnt_unexpected", 32'(gnt), 32'd0);
                    else begin
                        cur = exp_q.pop_front();
                        chk("gnt_order", 32'(gnt), 32'(1) << cur);
                    end
                end
                if (prev_stall) begin
                    chk("stall_valid", 32'(dst_valid), 32'd1);
                    chk("stall_data", dst_data, prev_data);
                    chk("stall_last", 32'(dst_last), 32'(prev_last));
                end
                if (dst_valid && !dst_ready) chk("stall_rd_v", 32'(rd_v), 32'd0);
                if (dst_valid && dst_ready) begin
                    chk("beat_data", dst_data, word(cur, bcnt));
                    chk("beat_last", 32'(dst_last), 32'(bcnt == 3));
                    n_beat++;
                    if (dst_last) n_last++;
                    bcnt++;
                end
                if (done != 4'd0) begin
                    chk("done_src", 32'(done), 32'(1) << cur);
                    chk("done_beats", 32'(bcnt), 32'd4);
                    n_done++;
                end
                prev_stall = dst_valid && !dst_ready;
                prev_data  = dst_data;
                prev_last  = dst_last;
                prev_gnt   = gnt;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] pat;
        pat       = 6'b101001;
        rst_n     = 1'b0;
        pend      = '0;
        dst_ready = 1'b1;
        b1_req    = '0;
        b1_ready  = 1'b1;

        // Reset values.
        #2;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_valid", 32'(dst_valid), 32'd0);
        chk("rst_data", dst_data, 32'd0);
        chk("rst_last", 32'(dst_last), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_i", 32'(rd_i), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_rd_v", 32'(rd_v), 32'd0);
            chk("idle_gnt", 32'(gnt), 32'd0);
        end

        // Rotation with every source requesting.
        @(posedge clk);
        #1;
        exp_q = '{0, 1, 2, 3, 0};
        pend  = 4'b1111;
        wait_done(4, 100);
        chk("rot_beats", 32'(n_beat), 32'd16);
        chk("rot_lasts", 32'(n_last), 32'd4);
        wait_gnt(5, 20);
        pend = 4'b0000;
        wait_done(5, 30);

        // Single source, cycle-exact latency.
        @(posedge clk);
        #1;
        exp_q.push_back(2);
        pend = 4'b0100;
        @(negedge clk);
        chk("s_gnt_pre", 32'(gnt), 32'd0);
        @(negedge clk);
        chk("s_gnt", 32'(gnt), 32'b0100);
        chk("s_rd_v0", 32'(rd_v), 32'd1);
        chk("s_rd_i0", 32'(rd_i), 32'd0);
        chk("s_valid0", 32'(dst_valid), 32'd0);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            chk("s_valid", 32'(dst_valid), 32'd1);
            chk("s_data", dst_data, 32'hA0 + 32'(b));
            chk("s_last", 32'(dst_last), 32'(b == 3));
            chk("s_rd_v", 32'(rd_v), 32'(b != 3));
        end
        @(negedge clk);
        chk("s_done", 32'(done), 32'b0100);
        chk("s_valid_off", 32'(dst_valid), 32'd0);
        chk("s_gnt_off", 32'(gnt), 32'd0);
        pend = 4'b0000;
        @(negedge clk);
        chk("s_done_pulse", 32'(done), 32'd0);

        // Pointer wrap: after source 3, source 0 wins over source 3.
        @(posedge clk);
        #1;
        exp_q.push_back(3);
        pend = 4'b1000;
        wait_done(7, 30);
        pend = 4'b0000;
        @(posedge clk);
        #1;
        exp_q.push_back(0);
        pend = 4'b1001;
        wait_gnt(n_gnt + 1, 10);
        chk("wrap_gnt", 32'(gnt), 32'b0001);
        pend = 4'b0000;
        wait_done(8, 30);

        // Backpressure with ready pattern 1,0,0,1,0,1 repeating.
        @(posedge clk);
        #1;
        exp_q.push_back(1);
        exp_q.push_back(2);
        pend = 4'b0110;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1 dst_ready = pat[k % 6];
            @(negedge clk);
            #1;
            if (n_done >= 10) begin
                pend = 4'b0000;
                break;
            end
        end
        chk("bp_done", 32'(n_done), 32'd10);
        chk("bp_beats", 32'(n_beat), 32'd40);
        @(posedge clk);
        #1 dst_ready = 1'b1;

        // One-beat instance, request dropped right after grant.
        b1_req = 4'b0001;
        @(negedge clk);
        chk("b1_gnt_pre", 32'(b1_gnt), 32'd0);
        @(posedge clk);
        #1 b1_req = 4'b0000;
        @(negedge clk);
        chk("b1_gnt", 32'(b1_gnt), 32'b0001);
        chk("b1_rd_v", 32'(b1_rd_v), 32'd1);
        @(negedge clk);
        chk("b1_valid", 32'(b1_valid), 32'd1);
        chk("b1_last", 32'(b1_last), 32'd1);
        chk("b1_data", b1_data, word(0, 0));
        chk("b1_rd_v_flush", 32'(b1_rd_v), 32'd0);
        @(negedge clk);
        chk("b1_done", 32'(b1_done), 32'b0001);
        chk("b1_valid_off", 32'(b1_valid), 32'd0);
        @(negedge clk);
        chk("b1_done_pulse", 32'(b1_done), 32'd0);
        chk("b1_idle_gnt", 32'(b1_gnt), 32'd0);
        chk("b1_idle_rd_v", 32'(b1_rd_v), 32'd0);

        // Reset in the middle of a burst.
        mon_en = 1'b0;
        @(posedge clk);
        #1 pend = 4'b0001;
        for (int k = 0; k < 10 && !dst_valid; k++) @(negedge clk);
        chk("mid_valid", 32'(dst_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(dst_valid), 32'd0);
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_last", 32'(dst_last), 32'd0);
        chk("mid_rst_rd_i", 32'(rd_i), 32'd0);
        @(posedge clk);
        #1 pend = 4'b0000;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_rd_v", 32'(rd_v), 32'd0);
            chk("post_rst_gnt", 32'(gnt), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
